// File: rtl/alu_opcode.sv
// ALU opcode encoding shared by the ALU (decoder side) and the control unit (encoder side).
package alu_opcode;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

endpackage

// File: rtl/ctrl_pkg.sv
// Control-unit types: FSM states, RV32I major opcodes and write-back source encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } ctrl_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    return (opc == OPC_OP)     || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE)  || (opc == OPC_BRANCH) || (opc == OPC_JAL)  ||
           (opc == OPC_JALR)   || (opc == OPC_LUI)    || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// Combinational mapping of opcode/funct3/funct7[5] onto the ALU opcode.
module alu_dec
  import alu_opcode::*;
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_op
);

  // Only OP/OP-IMM use funct3; SUB exists only for the register form.
  always_comb begin
    o_alu_op = ALU_ADD;
    if (i_opcode == OPC_LUI) begin
      o_alu_op = ALU_LUI;
    end else if ((i_opcode == OPC_OP) || (i_opcode == OPC_OP_IMM)) begin
      case (i_funct3)
        3'b000:  o_alu_op = ((i_opcode == OPC_OP) && i_funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  o_alu_op = ALU_SLL;
        3'b010:  o_alu_op = ALU_SLT;
        3'b011:  o_alu_op = ALU_SLTU;
        3'b100:  o_alu_op = ALU_XOR;
        3'b101:  o_alu_op = i_funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  o_alu_op = ALU_OR;
        default: o_alu_op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback strobes.
module multicycle_ctrl
  import alu_opcode::*;
  import ctrl_pkg::*;
#(
  parameter bit RESET_HALT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        instr_vld_i,
  input  logic        mem_rdy_i,
  input  logic        br_eq_i,
  input  logic        br_lt_i,
  output logic        ir_en_o,
  output logic        pc_en_o,
  output logic        pc_sel_o,
  output logic [3:0]  alu_op_o,
  output logic        op_a_sel_o,
  output logic        op_b_sel_o,
  output logic        br_uns_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        imem_req_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        illegal_o
);

  localparam ctrl_state_e RESET_STATE = RESET_HALT ? S_HALT : S_FETCH;

  ctrl_state_e r_state;
  ctrl_state_e w_next_state;
  logic        r_illegal;
  logic        w_set_illegal;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [3:0]  w_alu_op;
  logic        w_taken;
  logic        w_is_jump;
  logic        w_unused;

  assign w_opcode  = instr_i[6:0];
  assign w_funct3  = instr_i[14:12];
  assign w_taken   = w_funct3[2] ? (br_lt_i ^ w_funct3[0]) : (br_eq_i ^ w_funct3[0]);
  assign w_is_jump = (w_opcode == OPC_JAL) || (w_opcode == OPC_JALR);
  assign w_unused  = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};
  assign illegal_o = r_illegal;

  alu_dec u_alu_dec (
    .i_opcode   (w_opcode),
    .i_funct3   (w_funct3),
    .i_funct7b5 (instr_i[30]),
    .o_alu_op   (w_alu_op)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= RESET_STATE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_set_illegal = 1'b0;
    ir_en_o       = 1'b0;
    pc_en_o       = 1'b0;
    pc_sel_o      = 1'b0;
    alu_op_o      = ALU_ADD;
    op_a_sel_o    = 1'b0;
    op_b_sel_o    = 1'b0;
    br_uns_o      = 1'b0;
    rf_we_o       = 1'b0;
    wb_sel_o      = WB_ALU;
    imem_req_o    = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;

    case (r_state)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (instr_vld_i) begin
          ir_en_o      = 1'b1;
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_legal_opcode(w_opcode)) begin
          w_next_state = S_EXEC;
        end else begin
          w_set_illegal = 1'b1;
          w_next_state  = S_HALT;
        end
      end

      S_EXEC: begin
        alu_op_o = w_alu_op;
        case (w_opcode)
          OPC_OP: begin
            w_next_state = S_WB;
          end
          OPC_OP_IMM, OPC_LUI: begin
            op_b_sel_o   = 1'b1;
            w_next_state = S_WB;
          end
          OPC_AUIPC: begin
            op_a_sel_o   = 1'b1;
            op_b_sel_o   = 1'b1;
            w_next_state = S_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            op_b_sel_o   = 1'b1;
            w_next_state = S_MEM;
          end
          // funct3 010/011 are unassigned branch encodings
          OPC_BRANCH: begin
            if (w_funct3[2:1] == 2'b01) begin
              w_set_illegal = 1'b1;
              w_next_state  = S_HALT;
            end else begin
              op_a_sel_o   = 1'b1;
              op_b_sel_o   = 1'b1;
              br_uns_o     = w_funct3[1];
              pc_en_o      = 1'b1;
              pc_sel_o     = w_taken;
              w_next_state = S_FETCH;
            end
          end
          OPC_JAL, OPC_JALR: begin
            op_a_sel_o   = (w_opcode == OPC_JAL);
            op_b_sel_o   = 1'b1;
            pc_sel_o     = 1'b1;
            pc_en_o      = 1'b1;
            w_next_state = S_WB;
          end
          default: begin
            w_set_illegal = 1'b1;
            w_next_state  = S_HALT;
          end
        endcase
      end

      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (w_opcode == OPC_STORE);
        if (mem_rdy_i) begin
          if (w_opcode == OPC_STORE) begin
            pc_en_o      = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end
      end

      // Jumps already loaded the PC in EXEC, so only PC+4 goes to rd here.
      S_WB: begin
        rf_we_o      = 1'b1;
        pc_en_o      = !w_is_jump;
        wb_sel_o     = (w_opcode == OPC_LOAD) ? WB_LOAD : (w_is_jump ? WB_PC4 : WB_ALU);
        w_next_state = S_FETCH;
      end

      S_HALT: begin
        w_next_state = S_HALT;
      end

      default: begin
        w_next_state = RESET_STATE;
      end
    endcase

    // Strobes are forced quiet for as long as reset is held.
    if (!rst_ni) begin
      ir_en_o    = 1'b0;
      pc_en_o    = 1'b0;
      pc_sel_o   = 1'b0;
      alu_op_o   = ALU_ADD;
      op_a_sel_o = 1'b0;
      op_b_sel_o = 1'b0;
      br_uns_o   = 1'b0;
      rf_we_o    = 1'b0;
      wb_sel_o   = WB_ALU;
      imem_req_o = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a per-instruction cycle-trace reference model.
module tb_multicycle_ctrl;
  import alu_opcode::*;

  typedef struct packed {
    logic       illegal;
    logic       imem;
    logic       dmem;
    logic       dwe;
    logic       irEn;
    logic       pcEn;
    logic       pcSel;
    logic       aSel;
    logic       bSel;
    logic       brUns;
    logic       rfWe;
    logic [1:0] wbSel;
    logic [3:0] aluOp;
  } out_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        vld;
    logic        rdy;
    logic        eq;
    logic        lt;
    logic [2:0]  ph;
    out_t        exp;
  } step_t;

  localparam logic [6:0] M_OP = 7'h33, M_OPI = 7'h13, M_LD = 7'h03, M_ST = 7'h23;
  localparam logic [6:0] M_BR = 7'h63, M_JAL = 7'h6F, M_JALR = 7'h67, M_LUI = 7'h37, M_AUI = 7'h17;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] instr_i = '0;
  logic        instr_vld_i = 1'b0;
  logic        mem_rdy_i = 1'b0;
  logic        br_eq_i = 1'b0;
  logic        br_lt_i = 1'b0;
  logic        ir_en_o, pc_en_o, pc_sel_o, op_a_sel_o, op_b_sel_o, br_uns_o, rf_we_o;
  logic        imem_req_o, dmem_req_o, dmem_we_o, illegal_o;
  logic [3:0]  alu_op_o;
  logic [1:0]  wb_sel_o;

  int    errCount = 0;
  int    checkCount = 0;
  step_t steps[$];
  out_t  gotVec;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .instr_vld_i(instr_vld_i),
    .mem_rdy_i(mem_rdy_i), .br_eq_i(br_eq_i), .br_lt_i(br_lt_i), .ir_en_o(ir_en_o),
    .pc_en_o(pc_en_o), .pc_sel_o(pc_sel_o), .alu_op_o(alu_op_o), .op_a_sel_o(op_a_sel_o),
    .op_b_sel_o(op_b_sel_o), .br_uns_o(br_uns_o), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
    .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  assign gotVec = {illegal_o, imem_req_o, dmem_req_o, dmem_we_o, ir_en_o, pc_en_o, pc_sel_o,
                   op_a_sel_o, op_b_sel_o, br_uns_o, rf_we_o, wb_sel_o, alu_op_o};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic out_t idleOut();
    out_t e;
    e = '0;
    e.aluOp = ALU_ADD;
    return e;
  endfunction

  function automatic string phName(input logic [2:0] p);
    case (p)
      3'd0: return "fetchWait";
      3'd1: return "fetch";
      3'd2: return "decode";
      3'd3: return "exec";
      3'd4: return "memWait";
      3'd5: return "memDone";
      3'd6: return "writeback";
      default: return "halt";
    endcase
  endfunction

  function automatic logic knownOpc(input logic [6:0] opc);
    return opc inside {M_OP, M_OPI, M_LD, M_ST, M_BR, M_JAL, M_JALR, M_LUI, M_AUI};
  endfunction

  // Reference: the ALU operation the instruction names, by mnemonic.
  function automatic logic [3:0] expAlu(input logic [31:0] ins);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    if (opc == M_LUI) return ALU_LUI;
    if (opc != M_OP && opc != M_OPI) return ALU_ADD;
    case (f3)
      3'd0: return (opc == M_OP && ins[30]) ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return ins[30] ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic branchTaken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4, 3'd6: return lt;
      default: return !lt;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic pushStep(input logic [31:0] ins, input logic vld, input logic rdy,
                          input logic eq, input logic lt, input logic [2:0] ph, input out_t e);
    step_t s;
    s.instr = ins; s.vld = vld; s.rdy = rdy; s.eq = eq; s.lt = lt; s.ph = ph; s.exp = e;
    steps.push_back(s);
  endtask

  // Builds the expected per-cycle trace of one instruction; halts=1 if it ends in HALT.
  task automatic buildInstr(input logic [31:0] ins, input int fw, input int mw,
                            input logic eqX, input logic ltX, output bit halts);
    out_t       e;
    logic [6:0] opc;
    logic [2:0] f3;
    bit         toMem, toWb, isJump;
    opc    = ins[6:0];
    f3     = ins[14:12];
    halts  = 1'b0;
    toMem  = 1'b0;
    toWb   = 1'b0;
    isJump = (opc == M_JAL) || (opc == M_JALR);
    for (int i = 0; i < fw; i++) begin
      e = idleOut(); e.imem = 1'b1;
      pushStep($urandom, 1'b0, rb(), rb(), rb(), 3'd0, e);
    end
    e = idleOut(); e.imem = 1'b1; e.irEn = 1'b1;
    pushStep(ins, 1'b1, rb(), rb(), rb(), 3'd1, e);
    pushStep(ins, rb(), rb(), rb(), rb(), 3'd2, idleOut());
    if (!knownOpc(opc)) begin
      halts = 1'b1;
      return;
    end
    e = idleOut();
    e.aluOp = expAlu(ins);
    case (opc)
      M_OP:         toWb = 1'b1;
      M_OPI, M_LUI: begin e.bSel = 1'b1; toWb = 1'b1; end
      M_AUI:        begin e.aSel = 1'b1; e.bSel = 1'b1; toWb = 1'b1; end
      M_LD, M_ST:   begin e.bSel = 1'b1; toMem = 1'b1; end
      M_BR: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          halts = 1'b1;
        end else begin
          e.aSel  = 1'b1;
          e.bSel  = 1'b1;
          e.brUns = (f3 == 3'd6 || f3 == 3'd7);
          e.pcEn  = 1'b1;
          e.pcSel = branchTaken(f3, eqX, ltX);
        end
      end
      default: begin
        e.aSel = (opc == M_JAL); e.bSel = 1'b1; e.pcSel = 1'b1; e.pcEn = 1'b1; toWb = 1'b1;
      end
    endcase
    pushStep(ins, rb(), rb(), eqX, ltX, 3'd3, e);
    if (toMem) begin
      e = idleOut(); e.dmem = 1'b1; e.dwe = (opc == M_ST);
      for (int i = 0; i < mw; i++) pushStep(ins, rb(), 1'b0, rb(), rb(), 3'd4, e);
      e.pcEn = (opc == M_ST);
      pushStep(ins, rb(), 1'b1, rb(), rb(), 3'd5, e);
      toWb = (opc == M_LD);
    end
    if (toWb) begin
      e = idleOut();
      e.rfWe  = 1'b1;
      e.pcEn  = !isJump;
      e.wbSel = (opc == M_LD) ? 2'd1 : (isJump ? 2'd2 : 2'd0);
      pushStep(ins, rb(), rb(), rb(), rb(), 3'd6, e);
    end
  endtask

  task automatic applyStimulus(input int limit);
    step_t s;
    int    n;
    n = 0;
    while (steps.size() > 0 && (limit < 0 || n < limit)) begin
      s = steps.pop_front();
      @(posedge clk_i);
      #1;
      instr_i = s.instr; instr_vld_i = s.vld; mem_rdy_i = s.rdy;
      br_eq_i = s.eq; br_lt_i = s.lt;
      @(negedge clk_i);
      checkOutput(phName(s.ph), 32'(gotVec), 32'(s.exp));
      checkOutput("reqExclusive", {31'b0, imem_req_o & dmem_req_o}, 32'd0);
      n++;
    end
  endtask

  task automatic applyReset();
    out_t e;
    rst_ni = 1'b0; instr_vld_i = 1'b0; mem_rdy_i = 1'b0;
    #1;
    checkOutput("inReset", 32'(gotVec), 32'(idleOut()));
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    e = idleOut(); e.imem = 1'b1;
    checkOutput("postReset", 32'(gotVec), 32'(e));
  endtask

  task automatic runHalt(input int n);
    out_t e;
    e = idleOut(); e.illegal = 1'b1;
    for (int i = 0; i < n; i++) pushStep(instr_i, 1'b1, rb(), rb(), rb(), 3'd7, e);
    applyStimulus(-1);
  endtask

  task automatic runOne(input logic [31:0] ins, input int fw, input int mw,
                        input logic eqX, input logic ltX, input int haltCycles);
    bit halts;
    buildInstr(ins, fw, mw, eqX, ltX, halts);
    applyStimulus(-1);
    if (halts) begin
      runHalt(haltCycles);
      applyReset();
    end
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] ins;
    logic [6:0]  opc;
    int          k;
    ins = $urandom;
    k   = $urandom_range(0, 19);
    case (k)
      0, 1, 2: opc = M_OP;
      3, 4, 5: opc = M_OPI;
      6:       opc = M_LUI;
      7:       opc = M_AUI;
      8, 9:    opc = M_LD;
      10, 11:  opc = M_ST;
      12, 13, 14: opc = M_BR;
      15:      opc = M_JAL;
      16:      opc = M_JALR;
      17, 18:  opc = (k == 17) ? M_OP : M_BR;
      default: begin
        opc = 7'($urandom);
        while (knownOpc(opc)) opc = 7'($urandom);
      end
    endcase
    ins[6:0] = opc;
    return ins;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit halts;
    repeat (2) @(negedge clk_i);
    applyReset();

    runOne(32'h002081B3, 0, 0, 1'b0, 1'b0, 0);
    runOne(32'h402081B3, 1, 0, 1'b0, 1'b0, 0);
    runOne(32'h4020D193, 0, 0, 1'b0, 1'b0, 0);
    runOne(32'h0050B193, 2, 0, 1'b0, 1'b0, 0);
    runOne(32'h0000A183, 0, 3, 1'b0, 1'b0, 0);
    runOne(32'h00209063, 0, 0, 1'b1, 1'b0, 0);
    runOne(32'h0020F063, 0, 0, 1'b0, 1'b0, 0);
    runOne(32'h008000EF, 0, 0, 1'b0, 1'b0, 0);
    runOne(32'h0000007F, 0, 0, 1'b0, 1'b0, 20);

    buildInstr(32'h0020A023, 0, 6, 1'b0, 1'b0, halts);
    applyStimulus(5);
    steps.delete();
    @(posedge clk_i);
    #1;
    mem_rdy_i = 1'b0; instr_vld_i = 1'b0;
    checkOutput("swMemWe", {31'b0, dmem_we_o}, 32'd1);
    applyReset();

    for (int i = 0; i < 300; i++) begin
      runOne(randInstr(), $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb(), 5);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
